// File: rtl/axi_burst_writer.sv
// Stream-to-AXI4 burst writer: splits a word-count transfer into INCR bursts.
// Define AXI_BURST_WRITER_ERR_EN to enable the sticky bresp error flag.
module axi_burst_writer #(
  parameter int G_ID_WIDTH  = 1,
  parameter int G_MAX_BURST = 16,
  parameter int G_CNT_WIDTH = 16
) (
  input  logic                   s_aclk,
  input  logic                   s_areset,
  input  logic                   cmd_start,
  input  logic [31:0]            cmd_addr,
  input  logic [G_CNT_WIDTH-1:0] cmd_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic [31:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [G_ID_WIDTH-1:0]  m_axi_awid,
  output logic [31:0]            m_axi_awaddr,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [31:0]            m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  output logic                   m_axi_wlast,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_addr;
  logic [G_CNT_WIDTH-1:0] r_rem;
  logic [7:0]             r_awlen;
  logic [8:0]             r_wcnt;

  logic [8:0]             w_cur_beats;
  logic [31:0]            w_next_addr;
  logic [G_CNT_WIDTH-1:0] w_next_rem;
  logic [8:0]             w_next_beats;
  logic [8:0]             w_start_beats;
  logic                   w_unused;

  // Words to the next 4 KB page, capped by burst limit and remaining count.
  function automatic logic [8:0] f_beats(
    input logic [9:0]             aw,
    input logic [G_CNT_WIDTH-1:0] rem
  );
    int v_lim;
    v_lim = 1024 - int'(aw);
    if (v_lim > G_MAX_BURST) v_lim = G_MAX_BURST;
    if (int'(rem) < v_lim) v_lim = int'(rem);
    return 9'(v_lim);
  endfunction

  assign w_cur_beats   = {1'b0, r_awlen} + 9'd1;
  assign w_next_addr   = r_addr + {21'd0, w_cur_beats, 2'b00};
  assign w_next_rem    = r_rem - G_CNT_WIDTH'(w_cur_beats);
  assign w_next_beats  = f_beats(w_next_addr[11:2], w_next_rem);
  assign w_start_beats = f_beats(cmd_addr[11:2], cmd_len);

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_awlen <= '0;
      r_wcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_addr  <= {cmd_addr[31:2], 2'b00};
              r_rem   <= cmd_len;
              r_awlen <= 8'(w_start_beats - 9'd1);
              r_state <= S_AW;
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            r_wcnt  <= w_cur_beats;
            r_state <= S_W;
          end
        end
        S_W: begin
          if (in_valid && m_axi_wready) begin
            r_wcnt <= r_wcnt - 9'd1;
            if (r_wcnt == 9'd1) r_state <= S_B;
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            r_addr <= w_next_addr;
            r_rem  <= w_next_rem;
            if (w_next_rem != '0) begin
              r_awlen <= 8'(w_next_beats - 9'd1);
              r_state <= S_AW;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_BURST_WRITER_ERR_EN
  logic r_err;

  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && cmd_start) begin
      r_err <= 1'b0;
    end else if (r_state == S_B && m_axi_bvalid &&
                 m_axi_bresp != 2'b00) begin
      r_err <= 1'b1;
    end
  end

  assign err      = r_err;
  assign w_unused = ^cmd_addr[1:0];
`else
  assign err      = 1'b0;
  assign w_unused = ^{m_axi_bresp, cmd_addr[1:0]};
`endif

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign in_ready      = (r_state == S_W) && m_axi_wready;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (r_state == S_AW);
  assign m_axi_wdata   = in_data;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = (r_state == S_W) && in_valid;
  assign m_axi_wlast   = (r_state == S_W) && (r_wcnt == 9'd1);
  assign m_axi_bready  = (r_state == S_B);

endmodule

// File: tb/tb_axi_burst_writer.sv
// Randomized scoreboard bench for axi_burst_writer.
// Checks bursts, beat data/order, done/busy/err and reset behaviour.
module tb_axi_burst_writer;
  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        s_areset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        busy, done, err;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;

  always #5 clk = ~clk;

  axi_burst_writer #(
    .G_ID_WIDTH (1),
    .G_MAX_BURST(MAXB),
    .G_CNT_WIDTH(16)
  ) dut (
    .s_aclk       (clk),
    .s_areset     (s_areset),
    .cmd_start    (cmd_start),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .m_axi_awid   (awid),
    .m_axi_awaddr (awaddr),
    .m_axi_awlen  (awlen),
    .m_axi_awsize (awsize),
    .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wlast  (wlast),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready)
  );

  int checks = 0;
  int failures = 0;

  logic [39:0] exp_aw[$];
  logic [32:0] exp_w[$];
  logic [31:0] stream_q[$];

  bit toggle = 1'b0;
  int err_abs = -1;
  int b_idx = 0;
  int cyc = 0;
  int aw_cnt = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit hs_w = 1'b0;
  bit hs_wlast = 1'b0;
  bit hs_b = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: burst split from page room, burst limit and word count.
  task automatic model(input logic [31:0] addr, input int len,
                       output int nb);
    logic [31:0] a;
    logic [31:0] d;
    int rem, room, b;
    a = addr & 32'hFFFF_FFFC;
    rem = len;
    nb = 0;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 4;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_aw.push_back({a, 8'(b - 1)});
      for (int k = 0; k < b; k++) begin
        d = $urandom;
        stream_q.push_back(d);
        exp_w.push_back({k == b - 1, d});
      end
      a = a + 32'(4 * b);
      rem = rem - b;
      nb++;
    end
  endtask

  // Monitor / scoreboard: samples 1 time unit before each rising edge.
  always begin : mon
    logic [39:0] ea;
    logic [32:0] ew;
    @(negedge clk);
    #4;
    cyc++;
    hs_w = 1'b0;
    hs_wlast = 1'b0;
    hs_b = 1'b0;
    if (s_areset) begin
      exp_aw.delete();
      exp_w.delete();
    end else begin
      if (cmd_start && !busy) start_cyc = cyc;
      if (awvalid) chk("aw_excl", {wvalid, in_ready, bready}, 0);
      if (bready) chk("b_excl", {wvalid, in_ready, awvalid}, 0);
      if (awvalid && awready) begin
        aw_cnt++;
        if (exp_aw.size() == 0) begin
          chk("aw_unexpected", {awaddr, awlen}, 0);
        end else begin
          ea = exp_aw.pop_front();
          chk("aw", {awaddr, awlen}, ea);
          chk("aw_const", {awid, awsize, awburst}, {1'b0, 3'b010, 2'b01});
        end
      end
      if (wvalid && wready) begin
        hs_w = 1'b1;
        hs_wlast = wlast;
        if (exp_w.size() == 0) begin
          chk("w_unexpected", {wlast, wdata}, 0);
        end else begin
          ew = exp_w.pop_front();
          chk("w", {in_ready, wlast, wdata, wstrb}, {1'b1, ew, 4'hF});
        end
      end
      if (bvalid && bready) hs_b = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Stream source and AXI slave, driven just after the falling edge.
  always begin : slv
    int bdly;
    bit bpend;
    @(negedge clk);
    #1;
    if (s_areset) begin
      bvalid = 1'b0;
      bpend = 1'b0;
    end else begin
      if (hs_w && stream_q.size() > 0) void'(stream_q.pop_front());
      if (hs_b) bvalid = 1'b0;
      if (hs_wlast) begin
        bpend = 1'b1;
        bdly = toggle ? int'($urandom_range(0, 3)) : 0;
      end
      if (bpend && !bvalid) begin
        if (bdly == 0) begin
          bvalid = 1'b1;
          bresp = (b_idx == err_abs) ? 2'b10 : 2'b00;
          b_idx++;
          bpend = 1'b0;
        end else begin
          bdly--;
        end
      end
    end
    awready = toggle ? ($urandom_range(0, 1) == 1) : 1'b1;
    wready = toggle ? ($urandom_range(0, 3) != 0) : 1'b1;
    in_valid = (stream_q.size() > 0) &&
               (toggle ? ($urandom_range(0, 1) == 1) : 1'b1);
    in_data = in_valid ? stream_q[0] : $urandom;
  end

  task automatic do_reset();
    @(negedge clk);
    s_areset = 1'b1;
    repeat (2) @(negedge clk);
    stream_q.delete();
    s_areset = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int len,
                         input bit tog, input int errb, input int lat);
    int nb, aw0, d0, t;
    bit exp_err;
    toggle = tog;
    model(addr, len, nb);
    exp_err = 1'b0;
`ifdef AXI_BURST_WRITER_ERR_EN
    exp_err = (errb >= 0 && errb < nb);
`endif
    err_abs = (errb >= 0) ? b_idx + errb : -1;
    aw0 = aw_cnt;
    d0 = done_cnt;
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_addr = addr;
    cmd_len = 16'(len);
    @(negedge clk);
    cmd_start = 1'b0;
    if (len > 0) chk("start_busy_err", {busy, err}, 2'b10);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      chk("done_timeout", 0, 1);
      do_reset();
    end else begin
      chk("idle_after", {busy, done, err}, {2'b00, exp_err});
      chk("done_once", done_cnt - d0, 1);
      chk("burst_count", aw_cnt - aw0, nb);
      chk("drained", exp_aw.size() + exp_w.size(), 0);
      if (lat > 0) chk("latency", done_cyc - start_cyc, lat);
    end
  endtask

  initial begin
    int nb, t, d0, l;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, err, awvalid, wvalid, wlast, bready,
                    in_ready}, 0);
    chk("rst_aw", {awaddr, awlen}, 0);
    s_areset = 1'b0;
    @(negedge clk);

    run_cmd(32'h0000_0000, 4, 1'b0, -1, 7);
    run_cmd(32'h0000_0100, 40, 1'b0, -1, -1);
    run_cmd(32'h0000_0FF8, 6, 1'b0, -1, -1);
    run_cmd(32'h0000_2000, 37, 1'b1, -1, -1);
    run_cmd(32'h0000_0000, 0, 1'b1, -1, 1);
    run_cmd(32'h0000_0100, 40, 1'b1, 1, -1);
    run_cmd(32'h0000_3FF3, 9, 1'b1, -1, -1);
    run_cmd(32'hFFFF_FFF0, 8, 1'b0, -1, -1);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      if (i % 2 == 1) a[11:0] = 12'(4096 - 4 * int'($urandom_range(1, 20)));
      l = int'($urandom_range(1, 50));
      run_cmd(a, l, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 3)) - 1, -1);
    end

    toggle = 1'b0;
    model(32'h0000_0000, 20, nb);
    d0 = done_cnt;
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_addr = 32'h0;
    cmd_len = 16'd20;
    @(negedge clk);
    cmd_start = 1'b0;
    t = 0;
    while (!wvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reach_w", wvalid, 1);
    s_areset = 1'b1;
    @(negedge clk);
    chk("midw_rst_ctl", {busy, done, err, awvalid, wvalid, wlast, bready,
                         in_ready}, 0);
    chk("midw_rst_aw", {awaddr, awlen}, 0);
    stream_q.delete();
    @(negedge clk);
    s_areset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midw_no_done", done_cnt - d0, 0);
    chk("midw_idle", busy, 0);

    run_cmd(32'h0000_0040, 4, 1'b0, -1, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_burst_writer.md
AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

Interface
REQ-001 Parameter G_ID_WIDTH, 1, width of m_axi_awid.
REQ-002 Parameter G_MAX_BURST, 16, maximum beats per burst (1..256).
REQ-003 Parameter G_CNT_WIDTH, 16, width of the transfer word count.
REQ-004 s_aclk  input  1  single clock; all logic on rising edge.
REQ-005 s_areset  input  1  reset, synchronous, active-high.
REQ-006 cmd_start  input  1  one-cycle request to begin a transfer.
REQ-007 cmd_addr  input  32  byte start address; bits [1:0] forced to 0.
REQ-008 cmd_len  input  G_CNT_WIDTH  number of 32-bit words to write.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse on transfer completion.
REQ-011 err  output  1  sticky write-response error flag.
REQ-012 in_data  input  32  stream word.
REQ-013 in_valid  input  1  stream word valid.
REQ-014 in_ready  output  1  stream word accepted when in_valid and in_ready are both high.
REQ-015 m_axi_awid  output  G_ID_WIDTH  constant 0.
REQ-016 m_axi_awaddr  output  32  burst start address.
REQ-017 m_axi_awlen  output  8  beats minus one.
REQ-018 m_axi_awsize  output  3  constant 3'b010.
REQ-019 m_axi_awburst  output  2  constant 2'b01 (INCR).
REQ-020 m_axi_awvalid, m_axi_awready  output/input  1  address handshake.
REQ-021 m_axi_wdata  output  32  equals in_data.
REQ-022 m_axi_wstrb  output  4  constant 4'hF.
REQ-023 m_axi_wlast, m_axi_wvalid, m_axi_wready  output/output/input  1  write data channel.
REQ-024 m_axi_bresp, m_axi_bvalid, m_axi_bready  input(2)/input/output  response channel.

Function
REQ-025 States: IDLE, AW, W, B, DONE. cmd_start in IDLE with cmd_len>0 latches addr and len, clears err, and goes to AW; cmd_start outside IDLE is ignored.
REQ-026 cmd_start with cmd_len=0: go to DONE directly; no AXI traffic; done asserts the following cycle.
REQ-027 Beats per burst = min(remaining, G_MAX_BURST, (4096 - addr[11:0])/4); no burst crosses a 4 KB boundary. Beats are registered on entry to AW; awlen = beats-1.
REQ-028 AW: awvalid held high with stable awaddr/awlen until awready is sampled high; then go to W.
REQ-029 W: wvalid = in_valid, in_ready = wready, combinational pass-through of data. Each handshake decrements the beat counter. wlast is high on the final beat. The wlast handshake goes to B.
REQ-030 in_ready is low in every state except W; wvalid and awvalid are never high together.
REQ-031 B: bready high. On bvalid: addr += 4*beats and remaining -= beats; go to AW if remaining>0, else go to DONE.
REQ-032 DONE: done high for exactly one cycle; next state is IDLE. busy is high in AW, W, B and DONE.
REQ-033 Address arithmetic is 32-bit modulo with no wrap detection; remaining is G_CNT_WIDTH wide and never underflows.
REQ-034 Throughput: one beat per cycle while in_valid and wready stay high; 2-cycle bubble minimum (B to AW) between bursts.
REQ-035 At most one outstanding burst; no new AW is issued before B completes.

Reset
REQ-036 s_areset high at a clock edge forces IDLE, with busy, done, err, awvalid, wvalid, wlast, bready and in_ready all at 0, counters 0, and awaddr/awlen at 0; this applies mid-burst with no completion of the burst.

Configuration
REQ-037 Macro AXI_BURST_WRITER_ERR_EN defined: err sets when bvalid & bready with bresp != 2'b00, stays set until the next accepted cmd_start, and the transfer continues. Not defined: err is tied 0 and bresp is ignored.

Verification
REQ-038 cmd_addr=0x0, cmd_len=4, stream always valid, slave always ready -> one AW with awlen=3, 4 beats with wlast on the 4th, done pulse, busy low after.
REQ-039 cmd_addr=0x100, cmd_len=40, G_MAX_BURST=16 -> three bursts at 0x100/0x140/0x180 with awlen 15/15/7.
REQ-040 cmd_addr=0xFF8, cmd_len=6 -> bursts at 0xFF8 (awlen=1) and 0x1000 (awlen=3).
REQ-041 in_valid toggling 50% and wready random -> data order preserved, no beat lost or duplicated; cmd_len=0 -> done with zero AW.
REQ-042 bresp=2'b10 on the 2nd burst with the macro defined -> err=1 until the next start; s_areset mid-W -> all valids are 0 the next cycle.
